// File: rtl/alu_mdu.sv
// alu_mdu: WIDTH-bit EX-stage ALU with an iterative multiply/divide unit.
//
// Combinational part: ADD/SUB/logic/compare/shift/LUI, result/zero/overflow
// follow A, B and ALUOp within the same cycle.
//
// Sequential part: radix-2 shift-add multiplier and restoring divider that
// share one accumulator/shift register pair. An operation takes WIDTH RUN
// cycles; hi/lo are written on the edge that enters DONE.
//
// Build option: define ALU_SIGNED_MULDIV_EN to accept MULT (1110) and
// DIV (1111). Without it those codes never start the unit.
//
// Handshake: start is a request qualified by ALUOp. It is accepted on a
// rising edge when start=1, busy=0 and ALUOp is an enabled muldiv code;
// operands are latched at that edge. busy is high for the WIDTH iteration
// cycles, then done pulses for exactly one cycle with hi/lo already valid.
// A new start may be accepted during the done cycle. Starts that are not
// accepted leave no trace.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_dbg_o
);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLTU  = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_LUI   = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
`ifdef ALU_SIGNED_MULDIV_EN
  localparam logic [3:0] OP_MULT  = 4'b1110;
  localparam logic [3:0] OP_DIV   = 4'b1111;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;

  assign add_res = A + B;
  assign sub_res = A - B;
  assign shamt   = A[SHW-1:0];

  // Select the ALU result and flag signed overflow for ADD/SUB only.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (ALUOp)
      OP_ADD: begin
        result   = add_res;
        overflow = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        result   = sub_res;
        overflow = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_XOR:  result = A ^ B;
      OP_NOR:  result = ~(A | B);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  result = B << shamt;
      OP_SRL:  result = B >> shamt;
      OP_SRA:  result = $signed(B) >>> shamt;
      OP_LUI:  result = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------------------------------------------------------------
  // Muldiv decode and accept
  // ---------------------------------------------------------------------
  logic             md_en;
  logic             md_signed;
  logic             md_div;
  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Decode which muldiv codes may start the unit in this build.
  always_comb begin
    md_en     = 1'b0;
    md_signed = 1'b0;
    case (ALUOp)
      OP_MULTU, OP_DIVU: md_en = 1'b1;
`ifdef ALU_SIGNED_MULDIV_EN
      OP_MULT, OP_DIV: begin
        md_en     = 1'b1;
        md_signed = 1'b1;
      end
`endif
      default: md_en = 1'b0;
    endcase
  end

  // Bit 0 of every muldiv code separates divide (1) from multiply (0).
  assign md_div = ALUOp[0];
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign accept = start && !busy && md_en;

  // Signed operations iterate on magnitudes; signs are restored at write.
  assign sa    = md_signed & A[WIDTH-1];
  assign sb    = md_signed & B[WIDTH-1];
  assign a_mag = sa ? (-A) : A;
  assign b_mag = sb ? (-B) : B;

  // ---------------------------------------------------------------------
  // Iteration datapath
  //   multiply: acc_q = running high half, qm_q = multiplier / low half,
  //             opnd_q = multiplicand
  //   divide:   acc_q = partial remainder, qm_q = dividend / quotient,
  //             opnd_q = divisor
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] qm_q;
  logic [WIDTH-1:0] opnd_q;
  logic [SHW-1:0]   cnt_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic             bzero_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             last_step;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_qm;

  assign last_step = (state_q == S_RUN) && (cnt_q == SHW'(WIDTH - 1));

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_addend = qm_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    div_shift  = {acc_q, qm_q[WIDTH-1]};
    div_trial  = div_shift - {1'b0, opnd_q};
    step_acc   = acc_q;
    step_qm    = qm_q;
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_acc = div_trial[WIDTH-1:0];
        step_qm  = {qm_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = div_shift[WIDTH-1:0];
        step_qm  = {qm_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_qm  = {mul_sum[0], qm_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_raw;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  // Apply sign correction and the divide-by-zero override to the final step.
  always_comb begin
    prod_raw = {step_acc, step_qm};
    prod_fix = neg_lo_q ? (-prod_raw) : prod_raw;
    if (is_div_q) begin
      fin_lo = bzero_q ? '1 : (neg_lo_q ? (-step_qm) : step_qm);
      // With a zero divisor the remainder magnitude is |A|, so restoring
      // the dividend sign yields A itself.
      fin_hi = neg_hi_q ? (-step_acc) : step_acc;
    end else begin
      fin_hi = prod_fix[2*WIDTH-1:WIDTH];
      fin_lo = prod_fix[WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: IDLE -> RUN on accept, RUN -> DONE after WIDTH steps,
  // DONE -> RUN on an immediate accept, else IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_RUN;
      S_RUN:  if (last_step) state_d = S_DONE;
      S_DONE: state_d = accept ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers and HI/LO write.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      acc_q    <= '0;
      qm_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (accept) begin
        acc_q    <= '0;
        qm_q     <= md_div ? a_mag : b_mag;
        opnd_q   <= md_div ? b_mag : a_mag;
        cnt_q    <= '0;
        is_div_q <= md_div;
        neg_lo_q <= sa ^ sb;
        neg_hi_q <= md_div ? sa : (sa ^ sb);
        bzero_q  <= (B == '0);
      end else if (state_q == S_RUN) begin
        acc_q <= step_acc;
        qm_q  <= step_qm;
        cnt_q <= cnt_q + 1'b1;
      end
      if (last_step) begin
        hi_q <= fin_hi;
        lo_q <= fin_lo;
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign state_dbg_o = state_q;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
Parametrised successor to the CPU's single-cycle ALU.
- Widens the datapath to WIDTH bits and extends the opcode to 4 bits: logic, compare, shift and LUI operations.
- Adds an iterative multiply/divide unit with a start/busy/done handshake and HI/LO result registers.
- Sits in the EX stage of the multicycle CPU; the control FSM stalls on busy.

Parameters:
WIDTH, 32, datapath width; power of two, >= 8
SHW, $clog2(WIDTH), shift-amount width; derived, do not override

Ports:
CLK  input  1  clock, rising-edge
Reset  input  1  synchronous, active-high reset
A  input  WIDTH  operand A; A[SHW-1:0] is the shift amount for shift ops
B  input  WIDTH  operand B
ALUOp  input  4  operation select
start  input  1  launches a multiply/divide when ALUOp is a muldiv code and busy=0
result  output  WIDTH  combinational ALU result
zero  output  1  result == 0
overflow  output  1  signed overflow, ADD/SUB only, else 0
busy  output  1  muldiv iteration in progress
done  output  1  one-cycle pulse: hi/lo updated this cycle
hi  output  WIDTH  HI register: product high half / remainder
lo  output  WIDTH  LO register: product low half / quotient

Behaviour:
- Interface: one clock CLK; Reset is synchronous and active-high.
- Reset values: busy=0, done=0, hi=0, lo=0, iteration counter=0. result, zero and overflow stay combinational.
- Combinational ops; result follows A, B, ALUOp in the same cycle, no register:
  - 0000 ADD A+B; 0001 SUB A-B (two's complement); 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLT: signed A<B gives 1, else 0. 0111 SLTU: unsigned A<B.
  - 1000 SLL: B<<A[SHW-1:0]. 1001 SRL: B>>A[SHW-1:0], logical. 1010 SRA: same shift, arithmetic.
  - 1011 LUI: B[WIDTH/2-1:0] placed in the upper half, lower half zero.
  - 1100 MULTU, 1101 DIVU, 1110 MULT, 1111 DIV: result=0.
- overflow on ADD: operand signs equal and result sign differs. On SUB: operand signs differ and result sign differs from A.
- zero = (result == 0), including for the muldiv codes (zero=1).
- Muldiv accept:
  - Accepted at a rising edge when start=1, busy=0, and ALUOp is a muldiv code enabled in this build.
  - At accept, A, B, the opcode and the operand signs are latched; later changes to A/B/ALUOp have no effect.
  - start on a non-muldiv code, or while busy=1, is ignored and has no side effect.
- FSM states:
  - IDLE: accept -> RUN, busy=1, counter=0.
  - RUN: one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes). After WIDTH steps -> DONE.
  - DONE: lasts one cycle; busy=0, done=1, hi/lo written at the edge entering DONE. Next state is IDLE.
  - A new start may be accepted in the DONE cycle: busy goes to 1 the next cycle while done drops.
- Latency: start accepted at edge 0 -> busy=1 for cycles 1..WIDTH -> done=1 in cycle WIDTH+1, with hi/lo valid in that same cycle.
- hi/lo hold their value between operations and change only on DONE entry or Reset.
- MULTU: {hi,lo} = full 2*WIDTH-bit unsigned product.
- DIVU: lo = quotient, hi = remainder.
- Divide by zero: completes with the normal latency; lo = all ones, hi = the dividend as latched.
- Reset during RUN aborts the operation: next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.

Optional Feature:
Macro ALU_SIGNED_MULDIV_EN.
- Defined: 1110 MULT and 1111 DIV are accepted.
  - Operands are converted to magnitudes at accept; the sign correction is applied when hi/lo are written, with no extra latency.
  - MULT: product negated if sA^sB.
  - DIV: quotient sign = sA^sB; remainder sign = sA.
  - Divide by zero: lo = all ones, hi = A.
- Not defined: 1110/1111 start is ignored (busy stays 0, hi/lo unchanged); result=0 for these codes.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> result=0x80000000, overflow=1, zero=0; SUB 5-5 -> result=0, zero=1, overflow=0.
- SRA B=0x80000000, A=4 -> 0xF8000000; SLTU A=1, B=0xFFFFFFFF -> 1; SLT same operands -> 0; LUI B=0x1234 -> 0x12340000.
- MULTU A=0xFFFFFFFF, B=2, start at edge 0 -> busy=1 for cycles 1..32, done=1 in cycle 33 only, hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 100/7 -> lo=14, hi=2. DIVU 100/0 -> lo=0xFFFFFFFF, hi=100. start re-asserted with A=9, B=3 while busy -> ignored; first operation's values appear.
- Reset asserted in cycle 10 of a MULTU -> next cycle busy=0, done=0, hi=lo=0; no done pulse ever follows. Then DIVU 9/3 -> lo=3, hi=0 at normal latency.
- Macro defined: MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Macro undefined: start with ALUOp=1110 -> busy stays 0, hi/lo unchanged, result=0.
